// File: rtl/ram_arb_pkg.sv
// +----------------------------------------------------------------------------+
// | ram_arb_pkg: shared widths and typedefs for the RAM port arbiter.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package ram_arb_pkg;

  localparam int ADDR_W  = 15;
  localparam int DATA_W  = 16;
  localparam int BURST_W = 4;

  typedef enum logic {
    REQ_DISP = 1'b0,
    REQ_CPU  = 1'b1
  } req_id_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } owner_t;

endpackage

`default_nettype wire

// File: rtl/ram_arb_pick.sv
// +----------------------------------------------------------------------------+
// | ram_arb_pick: combinational winner selection (RAM_ARB_ROUND_ROBIN_EN).     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module ram_arb_pick
  import ram_arb_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic               req0,
  input  logic               req1,
  input  owner_t             state,
  input  logic [BURST_W-1:0] burst_cnt,
  output logic [1:0]         gnt
);

`ifdef RAM_ARB_ROUND_ROBIN_EN
  logic w_unused;
  assign w_unused = &{1'b0, burst_cnt, BURST_W'(MAX_BURST)};

  // On contention the requester that did not own the port last cycle wins.
  always_comb begin
    gnt = 2'b00;
    if (req0 && req1) begin
      if (state == OWN0) gnt = 2'b10;
      else               gnt = 2'b01;
    end else if (req0) begin
      gnt = 2'b01;
    end else if (req1) begin
      gnt = 2'b10;
    end
  end
`else
  logic w_unused;
  logic w_cpu_turn;
  assign w_unused   = &{1'b0, state};
  assign w_cpu_turn = req1 && (burst_cnt == BURST_W'(MAX_BURST));

  always_comb begin
    gnt = 2'b00;
    if (w_cpu_turn)  gnt = 2'b10;
    else if (req0)   gnt = 2'b01;
    else if (req1)   gnt = 2'b10;
  end
`endif

endmodule

`default_nettype wire

// File: rtl/ram_port_arbiter.sv
// +----------------------------------------------------------------------------+
// | ram_port_arbiter: shares one single-port RAM between display and CPU.      |
// | Optional macro: RAM_ARB_ROUND_ROBIN_EN.  Revision: 1.0                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W    = ram_arb_pkg::ADDR_W,
  parameter int DATA_W    = ram_arb_pkg::DATA_W,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] data_to_ram,
  output logic              web,
  input  logic [DATA_W-1:0] data_from_ram
);

  owner_t             r_state;
  owner_t             w_state_nxt;
  logic [BURST_W-1:0] w_burst_cnt;
  logic [1:0]         w_pick;
  logic [1:0]         w_gnt;
  logic               w_rd_start;
  req_id_t            w_win_id;
  logic               r_rd_pend;
  req_id_t            r_rd_id;

  ram_arb_pick #(
    .MAX_BURST (MAX_BURST)
  ) u_pick (
    .req0      (req0),
    .req1      (req1),
    .state     (r_state),
    .burst_cnt (w_burst_cnt),
    .gnt       (w_pick)
  );

  assign w_gnt = reset ? 2'b00 : w_pick;
  assign gnt0  = w_gnt[0];
  assign gnt1  = w_gnt[1];

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = IDLE;
    if (w_gnt[0])      w_state_nxt = OWN0;
    else if (w_gnt[1]) w_state_nxt = OWN1;
  end

`ifdef RAM_ARB_ROUND_ROBIN_EN
  assign w_burst_cnt = '0;
`else
  logic [BURST_W-1:0] r_burst_cnt;

  // Counts display grants only while the CPU is actually waiting.
  always_ff @(posedge clk) begin
    if (reset)                   r_burst_cnt <= '0;
    else if (w_gnt[1] || !req1)  r_burst_cnt <= '0;
    else if (w_gnt[0])           r_burst_cnt <= r_burst_cnt + 1'b1;
  end

  assign w_burst_cnt = r_burst_cnt;
`endif

  always_comb begin
    ram_address = '0;
    data_to_ram = '0;
    web         = 1'b0;
    w_rd_start  = 1'b0;
    w_win_id    = REQ_DISP;
    if (w_gnt[0]) begin
      ram_address = addr0;
      data_to_ram = wdata0;
      web         = we0;
      w_rd_start  = !we0;
      w_win_id    = REQ_DISP;
    end else if (w_gnt[1]) begin
      ram_address = addr1;
      data_to_ram = wdata1;
      web         = we1;
      w_rd_start  = !we1;
      w_win_id    = REQ_CPU;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_pend <= 1'b0;
      r_rd_id   <= REQ_DISP;
    end else begin
      r_rd_pend <= w_rd_start;
      if (w_rd_start) r_rd_id <= w_win_id;
    end
  end

  // Gating with reset drops a response that lands in the reset cycle itself.
  assign rvalid0 = r_rd_pend && !reset && (r_rd_id == REQ_DISP);
  assign rvalid1 = r_rd_pend && !reset && (r_rd_id == REQ_CPU);
  assign rdata0  = data_from_ram;
  assign rdata1  = data_from_ram;

endmodule

`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_ram_port_arbiter: self-checking bench with read-response scoreboard.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_ram_port_arbiter;

  localparam int AW = 15;
  localparam int DW = 16;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1, web;
  logic [DW-1:0] rdata0, rdata1, data_to_ram, data_from_ram;
  logic [AW-1:0] ram_address;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [DW-1:0] mem    [0:32767];
  logic [DW-1:0] shadow [0:32767];

  typedef struct {
    int            due;
    int            id;
    logic [DW-1:0] data;
  } exp_t;
  exp_t sb[$];

  ram_port_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .MAX_BURST (MB)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req0          (req0),
    .req1          (req1),
    .we0           (we0),
    .we1           (we1),
    .addr0         (addr0),
    .addr1         (addr1),
    .wdata0        (wdata0),
    .wdata1        (wdata1),
    .gnt0          (gnt0),
    .gnt1          (gnt1),
    .rvalid0       (rvalid0),
    .rvalid1       (rvalid1),
    .rdata0        (rdata0),
    .rdata1        (rdata1),
    .ram_address   (ram_address),
    .data_to_ram   (data_to_ram),
    .web           (web),
    .data_from_ram (data_from_ram)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Synchronous single-port RAM: one-cycle read latency, write on the edge.
  always @(posedge clk) begin
    if (web) mem[ram_address] <= data_to_ram;
    data_from_ram <= mem[ram_address];
  end

  // Read-response scoreboard: every cycle rvalid must match the queue head.
  always @(negedge clk) begin
    logic          ev0, ev1;
    logic [DW-1:0] ed;
    ev0 = 1'b0;
    ev1 = 1'b0;
    ed  = '0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      ev0 = (sb[0].id == 0);
      ev1 = (sb[0].id == 1);
      ed  = sb[0].data;
      void'(sb.pop_front());
    end
    checks++;
    if (rvalid0 !== ev0 || rvalid1 !== ev1) begin
      errors++;
      $display("FAIL rvalid cyc=%0d: got rvalid0=%b rvalid1=%b, expected %b %b",
               cyc, rvalid0, rvalid1, ev0, ev1);
    end
    if (ev0 || ev1) begin
      checks++;
      if ((ev0 ? rdata0 : rdata1) !== ed) begin
        errors++;
        $display("FAIL rdata cyc=%0d: got %h, expected %h", cyc, ev0 ? rdata0 : rdata1, ed);
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1; req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    addr0 = 15'h0005; addr1 = 15'h0006; wdata0 = 16'hAAAA; wdata1 = 16'h5555;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
        errors++;
        $display("FAIL reset_gnt: got %b%b, expected 00", gnt1, gnt0);
      end
      checks++;
      if (web !== 1'b0 || ram_address !== '0 || data_to_ram !== '0) begin
        errors++;
        $display("FAIL reset_ram: got web=%b addr=%h data=%h, expected 0 0 0",
                 web, ram_address, data_to_ram);
      end
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      errors++;
      $display("FAIL first_grant: got gnt1=%b gnt0=%b, expected 0 1", gnt1, gnt0);
    end
    sb.push_back('{cyc + 1, 0, shadow[addr0]});
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    @(posedge clk); #1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 15'h2400;
    @(negedge clk);
    checks++;
    if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
      errors++;
      $display("FAIL single_read_gnt: got gnt1=%b gnt0=%b, expected 1 0", gnt1, gnt0);
    end
    checks++;
    if (ram_address !== 15'h2400 || web !== 1'b0) begin
      errors++;
      $display("FAIL single_read_bus: got addr=%h web=%b, expected 2400 0", ram_address, web);
    end
    sb.push_back('{cyc + 1, 1, 16'hBEEF});
    @(posedge clk); #1;
    req1 = 1'b0;
    @(negedge clk);
    checks++;
    if (rvalid0 !== 1'b0) begin
      errors++;
      $display("FAIL single_read_rv0: got %b, expected 0", rvalid0);
    end
  endtask

  task automatic test_write();
    @(posedge clk); #1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 15'h0010; wdata0 = 16'h1234;
    @(negedge clk);
    checks++;
    if (gnt0 !== 1'b1 || web !== 1'b1 || ram_address !== 15'h0010 || data_to_ram !== 16'h1234) begin
      errors++;
      $display("FAIL write_bus: got gnt0=%b web=%b addr=%h data=%h, expected 1 1 0010 1234",
               gnt0, web, ram_address, data_to_ram);
    end
    shadow[15'h0010] = 16'h1234;
    @(posedge clk); #1;
    we0 = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt0 !== 1'b1 || web !== 1'b0) begin
      errors++;
      $display("FAIL readback_gnt: got gnt0=%b web=%b, expected 1 0", gnt0, web);
    end
    sb.push_back('{cyc + 1, 0, shadow[15'h0010]});
    @(posedge clk); #1;
    req0 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      req0 = 1'b1; we0 = 1'b0; addr0 = AW'(32'h300 + i);
      @(negedge clk);
      checks++;
      if (gnt0 !== 1'b1 || ram_address !== addr0) begin
        errors++;
        $display("FAIL b2b_%0d: got gnt0=%b addr=%h, expected 1 %h", i, gnt0, ram_address, addr0);
      end
      sb.push_back('{cyc + 1, 0, shadow[addr0]});
    end
    @(posedge clk); #1;
    req0 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_arbitration();
    int bc   = 0;
    int last = 0;
    int wait1 = 0;
    int exp;
    for (int i = 0; i < 21; i++) begin
      @(posedge clk); #1;
      req0 = 1'b1; we0 = 1'b0; we1 = 1'b0;
      req1 = (i != 10);
      addr0 = AW'(32'h100 + i); addr1 = AW'(32'h200 + i);
      @(negedge clk);
      if (!req1) exp = 0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      else if (i == 0) exp = 0;
      else exp = (last == 0) ? 1 : 0;
`else
      else exp = (bc == MB) ? 1 : 0;
`endif
      checks++;
      if (gnt0 !== (exp == 0) || gnt1 !== (exp == 1)) begin
        errors++;
        $display("FAIL arb_%0d: got gnt1=%b gnt0=%b, expected winner %0d", i, gnt1, gnt0, exp);
      end
      if (gnt1 === 1'b1 || !req1) wait1 = 0;
      else wait1++;
      checks++;
      if (wait1 > MB) begin
        errors++;
        $display("FAIL cpu_wait_%0d: got wait %0d, expected at most %0d", i, wait1, MB);
      end
      sb.push_back('{cyc + 1, exp, shadow[exp == 1 ? addr1 : addr0]});
      last = exp;
      if (!req1 || exp == 1) bc = 0;
      else bc++;
    end
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_cpu_alone();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      req1 = 1'b1; we1 = 1'b1; addr1 = AW'(32'h400 + i); wdata1 = DW'(32'hC000 + i);
      @(negedge clk);
      checks++;
      if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || web !== 1'b1 || data_to_ram !== wdata1) begin
        errors++;
        $display("FAIL cpu_alone_%0d: got gnt1=%b web=%b data=%h, expected 1 1 %h",
                 i, gnt1, web, data_to_ram, wdata1);
      end
      shadow[addr1] = wdata1;
    end
    @(posedge clk); #1;
    req1 = 1'b0; we1 = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 15'h0403;
    @(negedge clk);
    checks++;
    if (gnt0 !== 1'b1) begin
      errors++;
      $display("FAIL cpu_readback_gnt: got %b, expected 1", gnt0);
    end
    sb.push_back('{cyc + 1, 0, shadow[15'h0403]});
    @(posedge clk); #1;
    req0 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_read();
    @(posedge clk); #1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 15'h2400;
    @(negedge clk);
    checks++;
    if (gnt0 !== 1'b1) begin
      errors++;
      $display("FAIL midread_gnt: got %b, expected 1", gnt0);
    end
    @(posedge clk); #1;
    reset = 1'b1; req0 = 1'b0;
    @(negedge clk);
    checks++;
    if (rvalid0 !== 1'b0 || gnt0 !== 1'b0) begin
      errors++;
      $display("FAIL midread_n1: got rvalid0=%b gnt0=%b, expected 0 0", rvalid0, gnt0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (rvalid0 !== 1'b0) begin
      errors++;
      $display("FAIL midread_n2: got rvalid0=%b, expected 0", rvalid0);
    end
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) begin
      mem[i]    = DW'(i * 3 + 7);
      shadow[i] = DW'(i * 3 + 7);
    end
    mem[15'h2400]    = 16'hBEEF;
    shadow[15'h2400] = 16'hBEEF;
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

    test_reset();
    test_single_read();
    test_write();
    test_back_to_back();
    test_arbitration();
    test_cpu_alone();
    test_reset_mid_read();

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Shares the single-port 32K×16 system RAM between two requesters: requester 0 (display/DMA fetcher, latency-sensitive) and requester 1 (the CPU core). The arbiter sits between the requesters and the RAM port (ram_address, data_to_ram, web, data_from_ram). It grants at most one access per cycle, returns read data with a one-cycle latency, and prevents either side from starving the other.

## Interface
Parameters:
- ADDR_W, 15, RAM word-address width.
- DATA_W, 16, RAM data width.
- MAX_BURST, 4, the maximum number of consecutive requester-0 grants while requester 1 waits (fixed-priority mode only); legal range 1–15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req0 / req1  in  1  access request; held until the matching gnt.
- we0 / we1  in  1  1 = write, 0 = read; stable while req is high.
- addr0 / addr1  in  ADDR_W  word address; stable while req is high.
- wdata0 / wdata1  in  DATA_W  write data; stable while req is high.
- gnt0 / gnt1  out  1  combinational grant in the accepting cycle.
- rvalid0 / rvalid1  out  1  read data valid, one cycle after a granted read.
- rdata0 / rdata1  out  DATA_W  equal to data_from_ram; meaningful only when rvalid is high.
- ram_address  out  ADDR_W  to RAM.
- data_to_ram  out  DATA_W  to RAM.
- web  out  1  RAM write enable, active high.
- data_from_ram  in  DATA_W  RAM read data; valid the cycle after the address is presented.

## Operation
- Each cycle the arbiter selects a winner among the active requests. gnt for the winner is high in that same cycle. ram_address, data_to_ram and web are muxed combinationally from the winner.
- When there is no winner: ram_address=0, data_to_ram=0, web=0.
- Write: web=we of the winner in the grant cycle. A granted write completes in that cycle and produces no rvalid.
- Read: the read tag register records the winner id (rd_pend, rd_id). In the next cycle rvalid[rd_id]=1 and rdata=data_from_ram.
- A requester may drop req after gnt, or keep it high to issue back-to-back accesses (one per granted cycle).
- Arbitration states (registered last-owner):
  - IDLE: no grant last cycle.
  - OWN0: last grant went to requester 0.
  - OWN1: last grant went to requester 1.
  - Transitions: a grant to 0 moves to OWN0, a grant to 1 moves to OWN1, no grant moves to IDLE.
- Fixed-priority mode (default):
  - Requester 0 wins unless burst_cnt==MAX_BURST and req1 is high; in that case requester 1 wins.
  - burst_cnt (4-bit) increments on each grant to 0 while req1 is high.
  - burst_cnt clears on any grant to 1 and on any cycle where req1 is low.
- Simultaneous events:
  - req0 and req1 rise in the same cycle: the priority rule applies.
  - A read response and a new grant in the same cycle are independent; the pipeline is full-throughput.
- Reset has priority over everything.
  - Clears state to IDLE, burst_cnt=0, rd_pend=0.
  - An in-flight read is discarded: no rvalid in the cycle after reset.
  - gnt outputs are forced 0 while reset is high.

## Timing
- Grant latency: 0 cycles (same cycle as req, if it wins).
- Read latency: rvalid exactly 1 cycle after gnt for a read.
- Write latency: 0; the RAM captures data on the clock edge ending the grant cycle.
- Reset values (and the values while reset is high):
  - gnt0=gnt1=0, rvalid0=rvalid1=0, web=0.
  - ram_address=0, data_to_ram=0.
  - rdata follows data_from_ram.
- Sustained throughput: 1 access per cycle.
- Worst-case wait for requester 1 in fixed mode: MAX_BURST cycles.
- No combinational path from data_from_ram to gnt.

## Configuration
- RAM_ARB_ROUND_ROBIN_EN defined: when both requesters are active, the one not equal to the last owner wins. From IDLE, requester 0 wins. burst_cnt and MAX_BURST are unused, and the counter logic is removed.
- Undefined: the fixed-priority with burst-limit behaviour described above.

## Structure
- Shared package ram_arb_pkg:
  - ADDR_W and DATA_W constants.
  - Requester-id typedef (REQ_DISP=0, REQ_CPU=1).
  - Owner-state typedef (IDLE, OWN0, OWN1).
- Sub-module ram_arb_pick:
  - Purely combinational winner selection.
  - Inputs: req0, req1, state, burst_cnt.
  - Outputs: gnt vector.
  - Holds the RAM_ARB_ROUND_ROBIN_EN conditional.
- Top level holds the state register, burst counter, read tag pipeline and RAM muxes.

## Test plan
- Reset: hold reset 2 cycles with req0=req1=1 → gnt0=gnt1=0, web=0, ram_address=0; first grant occurs in the cycle after reset drops.
- Single read: req1, we1=0, addr1=0x2400, RAM holds 0xBEEF → gnt1 in cycle N; rvalid1=1, rdata1=0xBEEF in cycle N+1; rvalid0 stays 0.
- Write: req0, we0=1, addr0=0x0010, wdata0=0x1234 → gnt0 and web=1 with ram_address=0x0010, data_to_ram=0x1234 in the same cycle; a later read of 0x0010 returns 0x1234.
- Burst limit (fixed mode, MAX_BURST=4): req0 and req1 held high continuously → grant pattern 0,0,0,0,1,0,0,0,0,1…; requester 1 never waits more than 4 cycles.
- Round robin (RAM_ARB_ROUND_ROBIN_EN): both requests held high → grants strictly alternate 0,1,0,1; req1 alone → gnt1 every cycle.
- Reset mid-read: grant a read to requester 0 in cycle N, assert reset in cycle N+1 → rvalid0=0 in N+1 and in N+2.
